// File: rtl/uart_tx_csr_sequencer.sv
// CSR-bus master: programs the UART baud/control CSRs after reset or on request,
// then drains a small byte FIFO into the UART by polling status, writing data and kicking send.
module uart_tx_csr_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] BAUD_DIV   = 32'd5208,
   parameter logic [31:0] CTRL_CFG   = 32'h0000_0023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_valid,
   input  logic [7:0]  tx_data,
   output logic        tx_ready,
   input  logic        cfg_reload,
   output logic        csr_wr,
   output logic        csr_rd,
   output logic [2:0]  csr_addr,
   output logic [31:0] csr_wdata,
   input  logic [31:0] csr_rdata,
   output logic        init_done,
   output logic        err_data_bits,
   output logic [15:0] sent_count
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned CSR_W = 37;
   localparam logic [2:0]  ADDR_BAUD = 3'd0;
   localparam logic [2:0]  ADDR_CTRL = 3'd1;
   localparam logic [2:0]  ADDR_STAT = 3'd2;
   localparam logic [2:0]  ADDR_DATA = 3'd3;
   localparam logic [31:0] SEND_BIT  = 32'h0000_0040;

   typedef enum logic [2:0] {
      CFG_BAUD, CFG_CTRL, IDLE, POLL, POLL_WAIT, WR_DATA, KICK, CLR
   } state_e;

   state_e           state;
   logic             started;
   logic             reload_pend;
   logic [CSR_W-1:0] csr_bus;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic             push, pop, empty;
   logic [7:0]       head;
   logic             unused_rdata;

   assign {csr_wr, csr_rd, csr_addr, csr_wdata} = csr_bus;
   assign unused_rdata = ^{csr_rdata[31:3], csr_rdata[1]};

   // CSR bus image for a given state; registered on entry so outputs track the current state
   function automatic logic [CSR_W-1:0] csr_for(input state_e s, input logic [7:0] data);
      logic [CSR_W-1:0] v;
      v = '0;
      case (s)
         CFG_BAUD: v = {1'b1, 1'b0, ADDR_BAUD, BAUD_DIV};
         CFG_CTRL: v = {1'b1, 1'b0, ADDR_CTRL, CTRL_CFG};
         POLL:     v = {1'b0, 1'b1, ADDR_STAT, 32'h0};
         WR_DATA:  v = {1'b1, 1'b0, ADDR_DATA, 24'h0, data};
         KICK:     v = {1'b1, 1'b0, ADDR_CTRL, CTRL_CFG | SEND_BIT};
         CLR:      v = {1'b1, 1'b0, ADDR_CTRL, CTRL_CFG};
         default:  v = '0;
      endcase
      return v;
   endfunction

   assign push       = tx_valid && tx_ready;
   assign pop        = (state == WR_DATA);
   assign wr_ptr_nxt = wr_ptr + PW'(push);
   assign rd_ptr_nxt = rd_ptr + PW'(pop);
   assign empty      = (wr_ptr == rd_ptr);
   assign head       = mem[rd_ptr[AW-1:0]];

   // FIFO pointers; tx_ready is registered from the next-cycle pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_ready <= 1'b1;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         tx_ready <= (wr_ptr_nxt != {~rd_ptr_nxt[AW], rd_ptr_nxt[AW-1:0]});
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
   end

   // Sequencer; the start flop holds off the first CFG_BAUD write by one edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= CFG_BAUD;
         started       <= 1'b0;
         reload_pend   <= 1'b0;
         csr_bus       <= '0;
         init_done     <= 1'b0;
         err_data_bits <= 1'b0;
         sent_count    <= '0;
      end else begin
         if (!started) begin
            started <= 1'b1;
            csr_bus <= csr_for(CFG_BAUD, head);
         end else begin
            case (state)
               CFG_BAUD: begin
                  state   <= CFG_CTRL;
                  csr_bus <= csr_for(CFG_CTRL, head);
               end
               CFG_CTRL: begin
                  state       <= IDLE;
                  csr_bus     <= csr_for(IDLE, head);
                  init_done   <= 1'b1;
                  reload_pend <= 1'b0;
               end
               IDLE: begin
                  if (reload_pend) begin
                     state   <= CFG_BAUD;
                     csr_bus <= csr_for(CFG_BAUD, head);
                  end else if (!empty) begin
                     state   <= POLL;
                     csr_bus <= csr_for(POLL, head);
                  end else begin
                     csr_bus <= csr_for(IDLE, head);
                  end
               end
               POLL: begin
                  state   <= POLL_WAIT;
                  csr_bus <= csr_for(POLL_WAIT, head);
               end
               POLL_WAIT: begin
                  if (csr_rdata[2]) err_data_bits <= 1'b1;
                  if (csr_rdata[0]) begin
                     state   <= POLL;
                     csr_bus <= csr_for(POLL, head);
                  end else begin
                     state   <= WR_DATA;
                     csr_bus <= csr_for(WR_DATA, head);
                  end
               end
               WR_DATA: begin
                  state   <= KICK;
                  csr_bus <= csr_for(KICK, head);
               end
               KICK: begin
                  state   <= CLR;
                  csr_bus <= csr_for(CLR, head);
               end
               CLR: begin
                  state      <= IDLE;
                  csr_bus    <= csr_for(IDLE, head);
                  sent_count <= sent_count + 16'd1;
               end
               default: begin
                  state   <= IDLE;
                  csr_bus <= '0;
               end
            endcase
         end
         // A request landing on the CFG_CTRL edge must survive its clear
         if (cfg_reload) reload_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_csr_sequencer.sv
// Directed bench for uart_tx_csr_sequencer: a scripted status-CSR responder plus a
// CSR event log checked against hand-computed transaction sequences.
module tb_uart_tx_csr_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_ready;
   logic        cfg_reload = 1'b0;
   logic        csr_wr, csr_rd;
   logic [2:0]  csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata = 32'h0;
   logic        init_done, err_data_bits;
   logic [15:0] sent_count;

   typedef struct {
      int          cyc;
      logic [36:0] ev;
   } ev_t;

   ev_t         evq[$];
   logic [31:0] resp_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   uart_tx_csr_sequencer dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .cfg_reload(cfg_reload), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .init_done(init_done),
      .err_data_bits(err_data_bits), .sent_count(sent_count)
   );

   always #5 clk = ~clk;

   // Log each cycle's CSR activity as the cycle closes
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (csr_wr || csr_rd) evq.push_back('{cyc, {csr_wr, csr_rd, csr_addr, csr_wdata}});
   end

   // Status CSR: scripted responses, idle (0) once the script runs out
   always @(posedge clk) begin
      if (csr_rd) begin
         if (resp_q.size() > 0) csr_rdata <= resp_q.pop_front();
         else                   csr_rdata <= 32'h0;
      end
   end

   function automatic logic [36:0] wr_ev(input logic [2:0] a, input logic [31:0] d);
      return {1'b1, 1'b0, a, d};
   endfunction

   function automatic logic [36:0] rd_ev();
      return {1'b0, 1'b1, 3'd2, 32'h0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_csr(input string tag, input logic [36:0] exp);
      chk(tag, 64'({csr_wr, csr_rd, csr_addr, csr_wdata}), 64'(exp));
   endtask

   task automatic push(input logic [7:0] b);
      int n = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      while (!tx_ready && n < 300) begin
         step();
         n++;
      end
      chk("push_accept", 64'(tx_ready), 64'd1);
      step();
      tx_valid = 1'b0;
   endtask

   task automatic wait_sent(input logic [15:0] target);
      int n = 0;
      while (sent_count !== target && n < 500) begin
         step();
         n++;
      end
      chk("wait_sent", 64'(sent_count), 64'(target));
   endtask

   function automatic int data_writes();
      int n = 0;
      foreach (evq[i]) if (evq[i].ev[36] && evq[i].ev[34:32] == 3'd3) n++;
      return n;
   endfunction

   // Checks the three cycles after reset release; called at the release negedge
   task automatic check_cfg(input string tag);
      step();
      chk_csr({tag, "_baud"}, wr_ev(3'd0, 32'd5208));
      chk({tag, "_init0"}, 64'(init_done), 64'd0);
      step();
      chk_csr({tag, "_ctrl"}, wr_ev(3'd1, 32'h23));
      step();
      chk_csr({tag, "_quiet"}, 37'h0);
      chk({tag, "_init1"}, 64'(init_done), 64'd1);
   endtask

   initial begin
      logic [36:0] exp5 [10];
      logic [7:0]  bytes3 [4];
      logic [7:0]  bytes4 [5];
      int          k;
      int          rcyc [$];

      // Reset state
      step(); step();
      chk_csr("rst_csr", 37'h0);
      chk("rst_init", 64'(init_done), 64'd0);
      chk("rst_err", 64'(err_data_bits), 64'd0);
      chk("rst_sent", 64'(sent_count), 64'd0);
      chk("rst_ready", 64'(tx_ready), 64'd1);

      // Configuration after release, then silence
      rst_n = 1'b1;
      evq.delete();
      check_cfg("cfg");
      repeat (6) step();
      chk("cfg_evcount", 64'(evq.size()), 64'd2);

      // Single byte, UART free: 7-cycle latency
      evq.delete();
      push(8'hA5);
      chk_csr("b1_idle", 37'h0);
      step(); chk_csr("b1_poll", rd_ev());
      step(); chk_csr("b1_pwait", 37'h0);
      step(); chk_csr("b1_data", wr_ev(3'd3, 32'hA5));
      step(); chk_csr("b1_kick", wr_ev(3'd1, 32'h63));
      step(); chk_csr("b1_clr", wr_ev(3'd1, 32'h23));
      chk("b1_sent_pre", 64'(sent_count), 64'd0);
      step(); chk_csr("b1_done", 37'h0);
      chk("b1_sent", 64'(sent_count), 64'd1);

      // Busy three times, then free; four bytes in order
      evq.delete();
      resp_q = '{32'h1, 32'h1, 32'h1, 32'h0};
      bytes3 = '{8'h11, 8'h22, 8'h33, 8'h44};
      foreach (bytes3[i]) push(bytes3[i]);
      wait_sent(16'd5);
      step(); step();
      foreach (evq[i]) begin
         if (evq[i].ev[36] && evq[i].ev[34:32] == 3'd3) break;
         if (evq[i].ev[35]) rcyc.push_back(evq[i].cyc);
      end
      chk("busy_reads", 64'(rcyc.size()), 64'd4);
      for (int i = 1; i < 4 && i < rcyc.size(); i++)
         chk("busy_spacing", 64'(rcyc[i] - rcyc[i-1]), 64'd2);
      k = 0;
      foreach (evq[i]) if (evq[i].ev[36] && evq[i].ev[34:32] == 3'd3) begin
         if (k < 4) chk("busy_order", 64'(evq[i].ev[7:0]), 64'(bytes3[k]));
         k++;
      end
      chk("busy_ndata", 64'(k), 64'd4);

      // Fill while busy: full after four, fifth held until the first pop
      evq.delete();
      for (int i = 0; i < 20; i++) resp_q.push_back(32'h1);
      bytes4 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      for (int i = 0; i < 4; i++) push(bytes4[i]);
      chk("full_ready", 64'(tx_ready), 64'd0);
      push(bytes4[4]);
      chk("hold5_pops", 64'(data_writes()), 64'd1);
      wait_sent(16'd10);
      step(); step();
      k = 0;
      foreach (evq[i]) if (evq[i].ev[36] && evq[i].ev[34:32] == 3'd3) begin
         if (k < 5) chk("full_order", 64'(evq[i].ev[7:0]), 64'(bytes4[k]));
         k++;
      end
      chk("full_ndata", 64'(k), 64'd5);

      // Reload during POLL_WAIT with data_bits_error reported
      evq.delete();
      resp_q = '{32'h4};
      push(8'h5A);
      push(8'h6B);
      k = 0;
      while (!csr_rd && k < 50) begin step(); k++; end
      chk("rl_poll_seen", 64'(csr_rd), 64'd1);
      step();
      cfg_reload = 1'b1;
      step();
      cfg_reload = 1'b0;
      wait_sent(16'd12);
      step(); step();
      chk("rl_err", 64'(err_data_bits), 64'd1);
      chk("rl_init", 64'(init_done), 64'd1);
      exp5[0] = rd_ev();
      exp5[1] = wr_ev(3'd3, 32'h5A);
      exp5[2] = wr_ev(3'd1, 32'h63);
      exp5[3] = wr_ev(3'd1, 32'h23);
      exp5[4] = wr_ev(3'd0, 32'd5208);
      exp5[5] = wr_ev(3'd1, 32'h23);
      exp5[6] = rd_ev();
      exp5[7] = wr_ev(3'd3, 32'h6B);
      exp5[8] = wr_ev(3'd1, 32'h63);
      exp5[9] = wr_ev(3'd1, 32'h23);
      chk("rl_evcount", 64'(evq.size()), 64'd10);
      for (int i = 0; i < 10 && i < evq.size(); i++)
         chk($sformatf("rl_ev%0d", i), 64'(evq[i].ev), 64'(exp5[i]));

      // Reset asserted during KICK with a second byte still queued
      push(8'h77);
      push(8'h88);
      k = 0;
      while (!(csr_wr && csr_addr == 3'd1 && csr_wdata == 32'h63) && k < 50) begin step(); k++; end
      chk("rst_kick_seen", 64'(csr_wdata), 64'h63);
      rst_n = 1'b0;
      #1;
      chk_csr("mid_rst_csr", 37'h0);
      chk("mid_rst_sent", 64'(sent_count), 64'd0);
      chk("mid_rst_init", 64'(init_done), 64'd0);
      chk("mid_rst_err", 64'(err_data_bits), 64'd0);
      chk("mid_rst_ready", 64'(tx_ready), 64'd1);
      step(); step(); step();
      rst_n = 1'b1;
      evq.delete();
      check_cfg("recfg");
      repeat (10) step();
      chk("recfg_evcount", 64'(evq.size()), 64'd2);
      chk("recfg_sent", 64'(sent_count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
